// File: rtl/dout_transmitter.sv
// Serialises eight 24-bit channel samples onto a four-line ADC-style data-output bus (dclk/drdy/din0..3).
// Define DOUT_TRANSMITTER_HEADER_EN to prefix each slot with an 8-bit header (32-bit slots instead of 24).
module dout_transmitter #(
    parameter int CLK_DIV   = 4,
    parameter int FRAME_GAP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] ch1_i,
    input  logic [23:0] ch2_i,
    input  logic [23:0] ch3_i,
    input  logic [23:0] ch4_i,
    input  logic [23:0] ch5_i,
    input  logic [23:0] ch6_i,
    input  logic [23:0] ch7_i,
    input  logic [23:0] ch8_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        drdy_o,
    output logic        dclk_o,
    output logic        din0_o,
    output logic        din1_o,
    output logic        din2_o,
    output logic        din3_o,
    output logic        done_o,
    output logic [1:0]  state_dbg_o
);
`ifdef DOUT_TRANSMITTER_HEADER_EN
    localparam int SLOT_BITS = 32;
`else
    localparam int SLOT_BITS = 24;
`endif
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] BIT_LAST = 7'(FRAME_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(FRAME_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

`ifdef DOUT_TRANSMITTER_HEADER_EN
    // Header: error flag (always clear), 3-bit channel index, four reserved zeros.
    function automatic logic [7:0] hdr(input logic [2:0] idx);
        hdr = {1'b0, idx, 4'b0000};
    endfunction
`endif

    state_t                        state_q, state_d;
    logic [7:0]                    div_q, div_d;
    logic                          dclk_q, dclk_d;
    logic [6:0]                    bit_q, bit_d;
    logic [7:0]                    gap_q, gap_d;
    logic [3:0][FRAME_BITS-1:0]    line_q, line_d;
    logic [3:0]                    din_q, din_d;
    logic                          drdy_q, drdy_d;
    logic                          done_q, done_d;
    logic                          ready_q, ready_d;
    logic                          tick, fall, rise;

    assign tick = (div_q == DIV_LAST);
    assign fall = tick & dclk_q;
    assign rise = tick & ~dclk_q;

    always_comb begin
        state_d = state_q;
        div_d   = tick ? 8'd0 : div_q + 8'd1;
        dclk_d  = tick ? ~dclk_q : dclk_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        line_d  = line_q;
        din_d   = din_q;
        drdy_d  = drdy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
`ifdef DOUT_TRANSMITTER_HEADER_EN
                    line_d[0] = {hdr(3'd0), ch1_i, hdr(3'd1), ch2_i};
                    line_d[1] = {hdr(3'd2), ch3_i, hdr(3'd3), ch4_i};
                    line_d[2] = {hdr(3'd4), ch5_i, hdr(3'd5), ch6_i};
                    line_d[3] = {hdr(3'd6), ch7_i, hdr(3'd7), ch8_i};
`else
                    line_d[0] = {ch1_i, ch2_i};
                    line_d[1] = {ch3_i, ch4_i};
                    line_d[2] = {ch5_i, ch6_i};
                    line_d[3] = {ch7_i, ch8_i};
`endif
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (fall) begin
                    state_d = SHIFT;
                    bit_d   = 7'd0;
                    drdy_d  = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        din_d[k]  = line_q[k][FRAME_BITS-1];
                        line_d[k] = line_q[k] << 1;
                    end
                end
            end
            SHIFT: begin
                if (fall) begin
                    drdy_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        done_d  = 1'b1;
                        din_d   = 4'b0000;
                        gap_d   = 8'd0;
                        state_d = (FRAME_GAP == 0) ? IDLE : GAP;
                    end else begin
                        bit_d = (bit_q == BIT_LAST) ? bit_q : bit_q + 7'd1;
                        for (int k = 0; k < 4; k++) begin
                            din_d[k]  = line_q[k][FRAME_BITS-1];
                            line_d[k] = line_q[k] << 1;
                        end
                    end
                end
            end
            GAP: begin
                // Leave half a period early so a waiting frame starts exactly FRAME_GAP periods after the last one.
                if (rise && gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else if (fall) begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            dclk_q  <= 1'b0;
            bit_q   <= 7'd0;
            gap_q   <= 8'd0;
            line_q  <= '0;
            din_q   <= 4'b0000;
            drdy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dclk_q  <= dclk_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            line_q  <= line_d;
            din_q   <= din_d;
            drdy_q  <= drdy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o     = ready_q;
    assign drdy_o      = drdy_q;
    assign dclk_o      = dclk_q;
    assign din0_o      = din_q[0];
    assign din1_o      = din_q[1];
    assign din2_o      = din_q[2];
    assign din3_o      = din_q[3];
    assign done_o      = done_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_dout_transmitter.sv
// Bench for dout_transmitter: instance a (CLK_DIV=4, FRAME_GAP=2) and instance b (CLK_DIV=1, FRAME_GAP=0).
module tb_dout_transmitter;
`ifdef DOUT_TRANSMITTER_HEADER_EN
  localparam int SLOT = 32;
`else
  localparam int SLOT = 24;
`endif
  localparam int FB    = 2 * SLOT;
  localparam int HDR   = SLOT - 24;
  localparam int A_DIV = 4;
  localparam int A_GAP = 2;
  localparam int B_DIV = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [23:0] a_ch[8];
  logic [23:0] b_ch[8];
  logic        a_valid, b_valid;
  logic        a_ready, a_drdy, a_dclk, a_done;
  logic        b_ready, b_drdy, b_dclk, b_done;
  logic [3:0]  a_din, b_din;
  logic [1:0]  a_state, b_state;

  dout_transmitter #(.CLK_DIV(A_DIV), .FRAME_GAP(A_GAP)) dut_a (
    .clk(clk), .reset(reset),
    .ch1_i(a_ch[0]), .ch2_i(a_ch[1]), .ch3_i(a_ch[2]), .ch4_i(a_ch[3]),
    .ch5_i(a_ch[4]), .ch6_i(a_ch[5]), .ch7_i(a_ch[6]), .ch8_i(a_ch[7]),
    .valid_i(a_valid), .ready_o(a_ready), .drdy_o(a_drdy), .dclk_o(a_dclk),
    .din0_o(a_din[0]), .din1_o(a_din[1]), .din2_o(a_din[2]), .din3_o(a_din[3]),
    .done_o(a_done), .state_dbg_o(a_state)
  );

  dout_transmitter #(.CLK_DIV(B_DIV), .FRAME_GAP(0)) dut_b (
    .clk(clk), .reset(reset),
    .ch1_i(b_ch[0]), .ch2_i(b_ch[1]), .ch3_i(b_ch[2]), .ch4_i(b_ch[3]),
    .ch5_i(b_ch[4]), .ch6_i(b_ch[5]), .ch7_i(b_ch[6]), .ch8_i(b_ch[7]),
    .valid_i(b_valid), .ready_o(b_ready), .drdy_o(b_drdy), .dclk_o(b_dclk),
    .din0_o(b_din[0]), .din1_o(b_din[1]), .din2_o(b_din[2]), .din3_o(b_din[3]),
    .done_o(b_done), .state_dbg_o(b_state)
  );

  // receiver looks at whichever instance sel picks
  logic       sel = 1'b0;
  logic       m_drdy, m_dclk, m_done;
  logic [3:0] m_din;
  assign m_drdy = sel ? b_drdy : a_drdy;
  assign m_dclk = sel ? b_dclk : a_dclk;
  assign m_done = sel ? b_done : a_done;
  assign m_din  = sel ? b_din  : a_din;

  int total = 0;
  int bad = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  logic [255:0] exp_q[$];

  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] exp_line(input logic [23:0] x, input logic [2:0] ix,
                                              input logic [23:0] y, input logic [2:0] iy);
`ifdef DOUT_TRANSMITTER_HEADER_EN
    return {1'b0, ix, 4'b0000, x, 1'b0, iy, 4'b0000, y};
`else
    if (ix == iy) return '0;
    return {x, y};
`endif
  endfunction

  function automatic logic [255:0] exp_frame(input logic [23:0] c[8]);
    logic [3:0][FB-1:0] e;
    for (int k = 0; k < 4; k++)
      e[k] = exp_line(c[2*k], 3'(2*k), c[2*k+1], 3'(2*k+1));
    return 256'(e);
  endfunction

  // driver tasks
  task automatic wait_ready(input bit which);
    int t = 0;
    while (!(which ? b_ready : a_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 256'(t >= 1000), 256'(0));
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) b_valid = 1'b1; else a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Collect one frame: bits sampled on dclk rising edges, timing counted in clk cycles.
  task automatic recv(output logic [3:0][FB-1:0] w, output int pre_cyc, output int drdy_cyc,
                      output int shift_cyc, output bit viol, output bit timed_out);
    int  t, bits;
    bit  started, done_seen, prev;
    w = '0; pre_cyc = 0; drdy_cyc = 0; shift_cyc = 0; viol = 0; timed_out = 0;
    t = 0; bits = 0; started = 0; done_seen = 0; prev = m_dclk;
    while (!done_seen && t < 3000) begin
      @(negedge clk);
      t++;
      if (started) shift_cyc++;
      if (m_drdy) begin
        drdy_cyc++;
        if (!started) begin
          started = 1;
          pre_cyc = t;
        end
      end else if (!started && m_din != 4'b0000) begin
        viol = 1;
      end
      if (started && m_dclk && !prev && bits < FB) begin
        for (int k = 0; k < 4; k++) w[k] = {w[k][FB-2:0], m_din[k]};
        bits++;
      end
      if (started && m_done) done_seen = 1;
      prev = m_dclk;
    end
    timed_out = !done_seen || (bits != FB);
  endtask

  initial begin
    logic [3:0][FB-1:0] w, w2;
    int pre, dcyc, scyc, pre2, dcyc2, scyc2, rises, d0, drdy_seen, t;
    bit viol, to, viol2, to2, prev;
    logic [23:0] save[8];

    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_ch[i] = '0;
      b_ch[i] = '0;
    end

    // reset state
    repeat (4) @(negedge clk);
    chk("rst_a_outs", 256'({a_dclk, a_drdy, a_din, a_done, a_ready}), 256'(0));
    chk("rst_b_outs", 256'({b_dclk, b_drdy, b_din, b_done, b_ready}), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", 256'(a_ready), 256'(1));
    chk("rst_b_ready", 256'(b_ready), 256'(1));

    // CLK_DIV=1, ch1=0x800001
    sel = 1'b1;
    b_ch = '{24'h800001, 24'h3C5A96, 24'h000000, 24'hFFFFFF,
             24'h7FFFFF, 24'h800000, 24'h000001, 24'hABCDEF};
    wait_ready(1);
    pulse(1);
    recv(w, pre, dcyc, scyc, viol, to);
    chk("b_timeout", 256'(to), 256'(0));
    chk("b_drdy_cyc", 256'(dcyc), 256'(2));
    chk("b_shift_cyc", 256'(scyc), 256'(2 * FB * B_DIV));
    chk("b_din0_ch1", 256'(w[0][FB-1-HDR -: 24]), 256'(24'h800001));
    chk("b_din0_ch2", 256'(w[0][23:0]), 256'(24'h3C5A96));
    chk("b_frame", 256'(w), exp_frame(b_ch));

    // CLK_DIV=4 frame, ch8=0x123456
    sel = 1'b0;
    a_ch = '{24'h111111, 24'hF00001, 24'h0A0B0C, 24'h876543,
             24'h5A5A5A, 24'hA5A5A5, 24'hFEDCBA, 24'h123456};
    wait_ready(0);
    pulse(0);
    chk("a_ready_low", 256'(a_ready), 256'(0));
    recv(w, pre, dcyc, scyc, viol, to);
    chk("a_timeout", 256'(to), 256'(0));
    chk("a_latency", 256'(pre >= 1 && pre <= 2 * A_DIV), 256'(1));
    chk("a_drdy_cyc", 256'(dcyc), 256'(2 * A_DIV));
    chk("a_shift_cyc", 256'(scyc), 256'(2 * FB * A_DIV));
    chk("a_ch8_data", 256'(w[3][23:0]), 256'(24'h123456));
    chk("a_frame", 256'(w), exp_frame(a_ch));
`ifdef DOUT_TRANSMITTER_HEADER_EN
    chk("hdr_ch8", 256'(w[3][SLOT-1 -: 8]), 256'(8'h70));
    chk("hdr_ch1", 256'(w[0][FB-1 -: 8]), 256'(8'h00));
`endif

    // valid with new data mid-frame is ignored
    save = a_ch;
    wait_ready(0);
    pulse(0);
    fork
      recv(w, pre, dcyc, scyc, viol, to);
      begin
        repeat (100) @(negedge clk);
        a_ch[0] = 24'h0F0F0F;
        a_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_ready", 256'(a_ready), 256'(0));
        a_valid = 1'b0;
      end
    join
    chk("mid_timeout", 256'(to), 256'(0));
    chk("mid_frame", 256'(w), exp_frame(save));
    wait_ready(0);

    // back-to-back frames with valid held high
    a_ch = '{24'h000001, 24'h000002, 24'hC00000, 24'h3FFFFF,
             24'h800000, 24'h7FFFFF, 24'h246802, 24'h13579B};
    @(negedge clk);
    a_valid = 1'b1;
    recv(w, pre, dcyc, scyc, viol, to);
    recv(w2, pre2, dcyc2, scyc2, viol2, to2);
    a_valid = 1'b0;
    chk("b2b_timeout", 256'({to, to2}), 256'(0));
    chk("b2b_frame1", 256'(w), exp_frame(a_ch));
    chk("b2b_frame2", 256'(w2), exp_frame(a_ch));
    chk("b2b_gap_cyc", 256'(pre2), 256'(2 * A_GAP * A_DIV));
    chk("b2b_gap_quiet", 256'(viol2), 256'(0));
    wait_ready(0);

    // reset at bit 10 abandons the frame
    a_ch = '{24'hDEADBE, 24'h0BADF0, 24'h112233, 24'h445566,
             24'h778899, 24'hAABBCC, 24'hDDEEFF, 24'h010203};
    pulse(0);
    rises = 0; t = 0; prev = a_dclk;
    while (rises < 10 && t < 2000) begin
      @(negedge clk);
      t++;
      if (a_dclk && !prev && (a_drdy || rises > 0)) rises++;
      prev = a_dclk;
    end
    chk("rstmid_reach", 256'(rises), 256'(10));
    d0 = a_done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_outs", 256'({a_dclk, a_drdy, a_din, a_done, a_ready}), 256'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drdy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (a_drdy || a_din != 4'b0000) drdy_seen++;
    end
    chk("rstmid_no_done", 256'(a_done_cnt - d0), 256'(0));
    chk("rstmid_no_bits", 256'(drdy_seen), 256'(0));
    chk("rstmid_ready", 256'(a_ready), 256'(1));
    a_ch = '{24'h600006, 24'h500005, 24'h400004, 24'h300003,
             24'h200002, 24'h100001, 24'hF0000F, 24'hE0000E};
    pulse(0);
    recv(w, pre, dcyc, scyc, viol, to);
    chk("rstmid_fresh_to", 256'(to), 256'(0));
    chk("rstmid_fresh", 256'(w), exp_frame(a_ch));

    // 100 random frames through instance b
    sel = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 8; i++) b_ch[i] = 24'($urandom_range(0, 32'h00FF_FFFF));
      exp_q.push_back(exp_frame(b_ch));
      wait_ready(1);
      pulse(1);
      recv(w, pre, dcyc, scyc, viol, to);
      chk("loop_timeout", 256'(to), 256'(0));
      chk("loop_frame", 256'(w), exp_q.pop_front());
    end
    repeat (4) @(negedge clk);
    chk("loop_ticks", 256'(b_done_cnt), 256'(101));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dout_transmitter.md
DOUT_TRANSMITTER -- requirements
Module: dout_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per dclk half-period (legal range 1..255).
REQ-002 SHALL have parameter FRAME_GAP, default 2, meaning idle dclk periods after each frame before ready_o reasserts.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ch1_i..ch8_i  input  24 each  signed channel samples.
REQ-006 SHALL have port valid_i  input  1  frame request; samples are captured when valid_i and ready_o are both high.
REQ-007 SHALL have port ready_o  output  1  high when idle and able to accept a frame.
REQ-008 SHALL have ports drdy_o, dclk_o, din0_o, din1_o, din2_o, din3_o  output  1 each  ADC serial data-output bus.
REQ-009 SHALL have port done_o  output  1  one-clk pulse at end of frame.

Function
REQ-010 SHALL generate dclk_o free-running: it toggles every CLK_DIV clk cycles, starts low after reset, and has period 2*CLK_DIV clk cycles.
REQ-011 SHALL register all bus outputs and change drdy_o/dinN_o only on the clk cycle dclk_o goes 1->0, so the receiver samples on dclk rising edges.
REQ-012 SHALL use states IDLE -> ARMED on accept -> SHIFT at next dclk falling edge -> GAP after last bit -> IDLE after FRAME_GAP dclk periods (FRAME_GAP=0: SHIFT -> IDLE directly).
REQ-013 SHALL hold ready_o high only in IDLE; valid_i outside IDLE SHALL be ignored, and captured samples SHALL stay stable for the whole frame.
REQ-014 SHALL assert drdy_o for exactly the first dclk period of SHIFT.
REQ-015 SHALL transmit each channel as one SLOT_BITS slot, MSB first, two consecutive slots per line: din0 ch1,ch2; din1 ch3,ch4; din2 ch5,ch6; din3 ch7,ch8.
REQ-016 SHALL make a frame 2*SLOT_BITS dclk periods long, with a bit counter that saturates and never wraps.
REQ-017 SHALL send 24-bit data two's complement unchanged, with no rounding or sign extension on the line.
REQ-018 SHALL hold drdy_o and dinN_o low in IDLE, ARMED and GAP.
REQ-019 SHALL pulse done_o for one clk on the dclk falling edge that ends the last bit period.
REQ-020 SHALL give latency from accept to drdy_o rising equal to the clk cycles until the next dclk falling edge, at most 2*CLK_DIV.

Reset
REQ-021 SHALL, while reset is high, force state IDLE, dclk_o=0, drdy_o=0, din0_o..din3_o=0, done_o=0 and ready_o=0, and clear the dclk divider and bit counter.
REQ-022 SHALL raise ready_o on the first clk after reset deasserts.
REQ-023 SHALL abandon an in-progress frame on reset mid-frame, with no done_o and no further bits.
REQ-024 SHALL give reset priority over valid_i when both are high in the same cycle.

Configuration
REQ-025 SHALL, with DOUT_TRANSMITTER_HEADER_EN defined, use SLOT_BITS=32: an 8-bit header {1'b0 error, 3-bit channel index 0..7, 4'b0000} precedes the 24 data bits, giving a 64-period frame.
REQ-026 SHALL, without DOUT_TRANSMITTER_HEADER_EN, use SLOT_BITS=24 with data only, giving a 48-period frame; the interface SHALL be identical in both builds.

Verification
REQ-027 SHALL cover: CLK_DIV=1, header off, ch1=0x800001, valid pulse -> drdy_o high for 2 clk; din0 shows 1,0x22,1 across 24 periods, then ch2; done_o after 96 clk of SHIFT.
REQ-028 SHALL cover: header on, ch8=0x123456 -> din3 second slot reads header 0x70 then 0x123456; din0 first slot header 0x00.
REQ-029 SHALL cover: valid_i held high continuously, FRAME_GAP=2 -> back-to-back frames separated by exactly 2 dclk periods of low drdy_o/din.
REQ-030 SHALL cover: new ch1_i value with valid_i mid-frame -> ignored; current frame bits unchanged; ready_o stays low.
REQ-031 SHALL cover: reset at bit 10 -> next clk all outputs 0; no done_o; a fresh frame is accepted and transmitted correctly afterwards.
REQ-032 SHALL cover: loopback into the team's DoutReader with 8 random signed values per frame for 100 frames -> reader ch1..ch8 outputs match sent values, and one reader tick per frame.
